// File: rtl/afe_spi_rx.sv
// afe_spi_rx: oversampling receiver for the write-only AFE SPI link
// (SCLK/SDI/LE). Each frame is reassembled in the sysClk domain and
// presented as a right-justified word with a one-cycle valid strobe and
// sticky error flags. Used for loopback checking of AFE programming and
// as a bus monitor.
//
// Ports:
//   sysClk      system clock, at least 4x SCLK
//   sysReset_n  synchronous active-low reset
//   spiClk      SPI clock (async, idle low)
//   spiSdi      SPI data, MSB first, sampled on SCLK rise
//   spiLe       latch enable; low while shifting, rising edge closes frame
//   rxData      last completed word, LSB = last bit shifted
//   rxBitCount  bit count of last completed frame (clamped to WORD_WIDTH)
//   rxValid     one-cycle strobe when rxData/rxBitCount update
//   lengthErr   sticky: frame closed with count != EXPECTED_BITS
//   overrunErr  sticky: more than WORD_WIDTH SCLK edges in one frame
//   timeoutErr  sticky: frame aborted because SCLK stalled
//   errClear    clears the sticky flags (a simultaneous set wins)
//   busy        high while a frame is being shifted in
module afe_spi_rx #(
  parameter int unsigned WORD_WIDTH     = 24,
  parameter int unsigned EXPECTED_BITS  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                            sysClk,
  input  logic                            sysReset_n,
  input  logic                            spiClk,
  input  logic                            spiSdi,
  input  logic                            spiLe,
  output logic [WORD_WIDTH-1:0]           rxData,
  output logic [$clog2(WORD_WIDTH+1):0]   rxBitCount,
  output logic                            rxValid,
  output logic                            lengthErr,
  output logic                            overrunErr,
  output logic                            timeoutErr,
  input  logic                            errClear,
  output logic                            busy
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Input synchronizers plus edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, le_sync;
  logic                   sclk_hist, le_hist;

  // Registered edge pulses; SDI and LE level share the same delay as SCLK
  logic sclk_rise_q, le_rise_q, sdi_q, le_q;

  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [WORD_WIDTH-1:0] rx_data_d;
  logic [CNT_W-1:0]      rx_cnt_d;
  logic                  rx_valid_d;
  logic                  len_set, ovr_set, tmo_set;
  logic                  timeout_hit;

  // Synchronizers and edge detection
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      sclk_sync   <= '0;
      sdi_sync    <= '0;
      le_sync     <= '0;
      sclk_hist   <= 1'b0;
      le_hist     <= 1'b0;
      sclk_rise_q <= 1'b0;
      le_rise_q   <= 1'b0;
      sdi_q       <= 1'b0;
      le_q        <= 1'b0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spiClk};
      sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], spiSdi};
      le_sync     <= {le_sync[SYNC_STAGES-2:0], spiLe};
      sclk_hist   <= sclk_sync[SYNC_STAGES-1];
      le_hist     <= le_sync[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
      le_rise_q   <= le_sync[SYNC_STAGES-1] & ~le_hist;
      sdi_q       <= sdi_sync[SYNC_STAGES-1];
      le_q        <= le_sync[SYNC_STAGES-1];
    end
  end

  // Stall detector: counter is cleared by every SCLK edge inside a frame
  assign timeout_hit = (state_q == SHIFT) && !sclk_rise_q && !le_rise_q &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register and datapath registers
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      rxData     <= '0;
      rxBitCount <= '0;
      rxValid    <= 1'b0;
      lengthErr  <= 1'b0;
      overrunErr <= 1'b0;
      timeoutErr <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      rxData     <= rx_data_d;
      rxBitCount <= rx_cnt_d;
      rxValid    <= rx_valid_d;
      lengthErr  <= len_set | (lengthErr & ~errClear);
      overrunErr <= ovr_set | (overrunErr & ~errClear);
      timeoutErr <= tmo_set | (timeoutErr & ~errClear);
      busy       <= (state_d == SHIFT);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sclk_rise_q && !le_q) state_d = SHIFT;
      end
      SHIFT: begin
        if (le_rise_q || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    rx_data_d  = rxData;
    rx_cnt_d   = rxBitCount;
    rx_valid_d = 1'b0;
    len_set    = 1'b0;
    ovr_set    = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      IDLE: begin
        // LE rising while idle is an empty frame and is ignored
        if (sclk_rise_q && !le_q) begin
          shift_d   = WORD_WIDTH'(sdi_q);
          bit_cnt_d = CNT_W'(1);
          tmo_d     = '0;
        end
      end
      SHIFT: begin
        if (sclk_rise_q) begin
          tmo_d = '0;
          if (bit_cnt_q < CNT_W'(WORD_WIDTH)) begin
            shift_d   = {shift_q[WORD_WIDTH-2:0], sdi_q};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            // Word is full: keep counting for the length check, drop the bit
            ovr_set = 1'b1;
            if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end

        // Close uses the post-shift word so a coincident last bit is kept
        if (le_rise_q) begin
          rx_valid_d = 1'b1;
          rx_data_d  = shift_d;
          rx_cnt_d   = (bit_cnt_d > CNT_W'(WORD_WIDTH)) ? CNT_W'(WORD_WIDTH)
                                                        : bit_cnt_d;
          len_set    = (bit_cnt_d != CNT_W'(EXPECTED_BITS));
        end else if (timeout_hit) begin
          tmo_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_afe_spi_rx.sv
module tb_afe_spi_rx;

  localparam int WW = 24;

  logic        sysClk = 1'b0;
  logic        sysReset_n = 1'b0;
  logic        spiClk = 1'b0;
  logic        spiSdi = 1'b0;
  logic        spiLe = 1'b0;
  logic        errClear = 1'b0;
  logic [23:0] rxData;
  logic [5:0]  rxBitCount;
  logic        rxValid, lengthErr, overrunErr, timeoutErr, busy;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  logic [23:0] cap_data = '0;
  logic [5:0]  cap_cnt = '0;

  afe_spi_rx dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .spiClk(spiClk),
    .spiSdi(spiSdi), .spiLe(spiLe), .rxData(rxData),
    .rxBitCount(rxBitCount), .rxValid(rxValid), .lengthErr(lengthErr),
    .overrunErr(overrunErr), .timeoutErr(timeoutErr), .errClear(errClear),
    .busy(busy)
  );

  always #5 sysClk = ~sysClk;

  // Strobe monitor
  always @(posedge sysClk) begin
    #1;
    if (rxValid) begin
      vcnt++;
      cap_data = rxData;
      cap_cnt  = rxBitCount;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  // SCLK = sysClk/8, data set up half a period before the rising edge
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spiSdi = v[i];
      tick(4);
      spiClk = 1'b1;
      tick(4);
      spiClk = 1'b0;
    end
  endtask

  task automatic pulse_le();
    tick(4);
    spiLe = 1'b1;
    tick(4);
    spiLe = 1'b0;
    tick(12);
  endtask

  task automatic clear_err();
    errClear = 1'b1;
    tick(1);
    errClear = 1'b0;
    tick(1);
  endtask

  task automatic run_frame(input logic [31:0] v, input int n, output int strobes);
    int v0;
    v0 = vcnt;
    send_bits(v, n);
    pulse_le();
    strobes = vcnt - v0;
  endtask

  // Reference: first WORD_WIDTH bits sent, MSB first, packed right-justified
  function automatic logic [23:0] model_data(input logic [31:0] v, input int n);
    bit q[$];
    logic [23:0] d;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    d = '0;
    for (int k = 0; k < q.size() && k < WW; k++) d = {d[22:0], q[k]};
    return d;
  endfunction

  function automatic logic [5:0] model_cnt(input int n);
    return (n > WW) ? 6'(WW) : 6'(n);
  endfunction

  task automatic test_reset();
    sysReset_n = 1'b0;
    tick(3);
    total++;
    if ({rxData, rxBitCount, rxValid, lengthErr, overrunErr, timeoutErr, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h cnt=%0d v=%b le=%b oe=%b te=%b busy=%b, want all 0",
               rxData, rxBitCount, rxValid, lengthErr, overrunErr, timeoutErr, busy);
    end
    sysReset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_nominal();
    int s;
    run_frame(32'hA5C3, 16, s);
    total++;
    if (s !== 1) begin bad++; $display("FAIL nominal_strobes: got %0d want 1", s); end
    total++;
    if (cap_data !== 24'h00A5C3) begin bad++; $display("FAIL nominal_data: got %h want 00a5c3", cap_data); end
    total++;
    if (cap_cnt !== 6'd16) begin bad++; $display("FAIL nominal_count: got %0d want 16", cap_cnt); end
    total++;
    if ({lengthErr, overrunErr, timeoutErr} !== 3'b000) begin
      bad++; $display("FAIL nominal_errs: got %b want 000", {lengthErr, overrunErr, timeoutErr});
    end
  endtask

  task automatic test_short();
    int s;
    run_frame(32'hFFF, 12, s);
    total++;
    if (s !== 1) begin bad++; $display("FAIL short_strobes: got %0d want 1", s); end
    total++;
    if (cap_data !== 24'h000FFF) begin bad++; $display("FAIL short_data: got %h want 000fff", cap_data); end
    total++;
    if (cap_cnt !== 6'd12) begin bad++; $display("FAIL short_count: got %0d want 12", cap_cnt); end
    total++;
    if (lengthErr !== 1'b1) begin bad++; $display("FAIL short_lenerr: got %b want 1", lengthErr); end
    clear_err();
    total++;
    if (lengthErr !== 1'b0) begin bad++; $display("FAIL short_clear: got %b want 0", lengthErr); end
  endtask

  task automatic test_overrun();
    int s;
    run_frame(32'h3FFFFFC, 26, s);
    total++;
    if (s !== 1) begin bad++; $display("FAIL overrun_strobes: got %0d want 1", s); end
    total++;
    if (cap_data !== 24'hFFFFFF) begin bad++; $display("FAIL overrun_data: got %h want ffffff", cap_data); end
    total++;
    if (cap_cnt !== 6'd24) begin bad++; $display("FAIL overrun_count: got %0d want 24", cap_cnt); end
    total++;
    if ({overrunErr, lengthErr} !== 2'b11) begin
      bad++; $display("FAIL overrun_errs: got oe=%b le=%b want 1 1", overrunErr, lengthErr);
    end
    clear_err();
  endtask

  task automatic test_timeout();
    int v0, s, waited;
    v0 = vcnt;
    send_bits(32'h15, 5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_start: got %b want 1", busy); end
    tick(3500);
    total++;
    if ({busy, timeoutErr} !== 2'b10) begin
      bad++; $display("FAIL timeout_early: got busy=%b te=%b want 1 0", busy, timeoutErr);
    end
    waited = 0;
    while (busy && waited < 1000) begin tick(1); waited++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_wait: busy=%b after bound, want 0", busy); end
    total++;
    if (timeoutErr !== 1'b1) begin bad++; $display("FAIL timeout_flag: got %b want 1", timeoutErr); end
    total++;
    if (vcnt !== v0) begin bad++; $display("FAIL timeout_nostrobe: got %0d strobes want 0", vcnt - v0); end
    clear_err();
    run_frame(32'hBEEF, 16, s);
    total++;
    if (s !== 1 || cap_data !== 24'h00BEEF || cap_cnt !== 6'd16) begin
      bad++; $display("FAIL timeout_recover: strobes=%0d data=%h cnt=%0d want 1 00beef 16", s, cap_data, cap_cnt);
    end
    total++;
    if ({lengthErr, overrunErr, timeoutErr} !== 3'b000) begin
      bad++; $display("FAIL timeout_recover_errs: got %b want 000", {lengthErr, overrunErr, timeoutErr});
    end
  endtask

  task automatic test_reset_mid();
    int v0, s;
    send_bits(32'hAB, 8);
    sysReset_n = 1'b0;
    tick(1);
    sysReset_n = 1'b1;
    v0 = vcnt;
    pulse_le();
    total++;
    if (vcnt !== v0) begin bad++; $display("FAIL rstmid_nostrobe: got %0d strobes want 0", vcnt - v0); end
    total++;
    if ({rxData, rxBitCount, lengthErr, overrunErr, timeoutErr, busy} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: data=%h cnt=%0d errs=%b busy=%b want all 0",
                      rxData, rxBitCount, {lengthErr, overrunErr, timeoutErr}, busy);
    end
    run_frame(32'h1234, 16, s);
    total++;
    if (s !== 1 || cap_data !== 24'h001234) begin
      bad++; $display("FAIL rstmid_next: strobes=%0d data=%h want 1 001234", s, cap_data);
    end
  endtask

  task automatic test_coincident();
    int v0, s;
    logic [15:0] v;
    v = 16'($urandom);
    v0 = vcnt;
    send_bits(32'(v >> 1), 15);
    spiSdi = v[0];
    tick(4);
    spiClk = 1'b1;
    spiLe  = 1'b1;
    tick(4);
    spiClk = 1'b0;
    tick(4);
    spiLe = 1'b0;
    tick(12);
    s = vcnt - v0;
    total++;
    if (s !== 1 || cap_data !== model_data(32'(v), 16) || cap_cnt !== 6'd16) begin
      bad++; $display("FAIL coincident: strobes=%0d data=%h cnt=%0d want 1 %h 16",
                      s, cap_data, cap_cnt, model_data(32'(v), 16));
    end
    total++;
    if (lengthErr !== 1'b0) begin bad++; $display("FAIL coincident_lenerr: got %b want 0", lengthErr); end
  endtask

  task automatic test_idle_le();
    int v0;
    logic [23:0] held;
    held = cap_data;
    v0 = vcnt;
    pulse_le();
    total++;
    if (vcnt !== v0) begin bad++; $display("FAIL idle_le_strobe: got %0d want 0", vcnt - v0); end
    total++;
    if ({lengthErr, overrunErr, timeoutErr, busy} !== 4'b0000) begin
      bad++; $display("FAIL idle_le_flags: got %b want 0000", {lengthErr, overrunErr, timeoutErr, busy});
    end
    total++;
    if (rxData !== held) begin bad++; $display("FAIL idle_le_hold: got %h want %h", rxData, held); end
  endtask

  task automatic test_random();
    int n, s;
    logic [31:0] v;
    for (int f = 0; f < 16; f++) begin
      n = int'($urandom_range(1, 28));
      v = $urandom;
      clear_err();
      run_frame(v, n, s);
      total++;
      if (s !== 1 || cap_data !== model_data(v, n) || cap_cnt !== model_cnt(n)) begin
        bad++; $display("FAIL random_frame n=%0d: strobes=%0d data=%h cnt=%0d want 1 %h %0d",
                        n, s, cap_data, cap_cnt, model_data(v, n), model_cnt(n));
      end
      total++;
      if (lengthErr !== (n != 16) || overrunErr !== (n > WW) || timeoutErr !== 1'b0) begin
        bad++; $display("FAIL random_flags n=%0d: le=%b oe=%b te=%b want %b %b 0",
                        n, lengthErr, overrunErr, timeoutErr, n != 16, n > WW);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_coincident();
    test_idle_le();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afe_spi_rx.md
Name: afe_spi_rx

Overview:
- Serial receiver for the AFE attenuator/switch SPI link: the receiving end of the write-only SCLK/SDI/LE bus that the DSBPM top drives per AFE (AFE_SPI_CLK/SDI/LE).
- Oversamples the asynchronous SPI lines in the system clock domain and reassembles each framed word.
- Presents the word with a one-cycle valid strobe plus error flags.
- Instantiated one per AFE lane for loopback self-check of AFE programming; also serves as the bus-functional monitor in AFE bench tests.

Parameters:
- WORD_WIDTH, 24, maximum bits accepted per frame (shift register width).
- EXPECTED_BITS, 16, bit count of a well-formed frame; any other count sets lengthErr.
- TIMEOUT_CYCLES, 4096, sysClk cycles without an SCLK rising edge inside a frame before the frame is aborted.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (min 2).

Ports:
- sysClk  in  1  system clock; all logic in this domain; must be at least 4x SCLK.
- sysReset_n  in  1  synchronous active-low reset, sampled on sysClk rising edge.
- spiClk  in  1  SPI clock from the bus, asynchronous, idle low.
- spiSdi  in  1  SPI data, MSB first, sampled on SCLK rising edge.
- spiLe  in  1  latch enable, asynchronous; low during shifting; rising edge ends the frame.
- rxData  out  WORD_WIDTH  last completed word, right-justified (LSB = last bit shifted).
- rxBitCount  out  $clog2(WORD_WIDTH+1)+1  number of bits in the last completed frame.
- rxValid  out  1  one-cycle strobe when rxData/rxBitCount update.
- lengthErr  out  1  sticky: a frame ended with bit count != EXPECTED_BITS.
- overrunErr  out  1  sticky: more than WORD_WIDTH SCLK edges in one frame.
- timeoutErr  out  1  sticky: a frame was aborted by timeout.
- errClear  in  1  synchronous pulse; clears all sticky flags.
- busy  out  1  high while state is SHIFT.

Behaviour:
- Synchronization and edge detection:
  - spiClk, spiSdi and spiLe each pass through SYNC_STAGES flops, plus one history flop for edge detect.
  - sclkRise = sync & ~hist; leRise likewise.
  - spiSdi uses the same synchronizer depth as spiClk, so the data sampled with sclkRise is the value present at the SCLK edge.
- Reset (sysReset_n low at a clock edge):
  - state=IDLE, shift register=0, bit counter=0, timeout counter=0.
  - rxData=0, rxBitCount=0, rxValid=0, all errors=0, busy=0.
  - Synchronizer flops reset to 0.
  - A frame in progress when reset asserts is discarded with no rxValid.
- State machine:
  - IDLE:
    - On sclkRise with synced LE low: load shift register with {zeros, sdi}, bitCnt=1, clear timeout counter, go to SHIFT.
    - leRise in IDLE (empty frame) is ignored; no strobe, no error.
  - SHIFT, sclkRise with LE low:
    - If bitCnt < WORD_WIDTH: shift = {shift[WORD_WIDTH-2:0], sdi}, bitCnt+1.
    - Else: set overrunErr and keep counting bitCnt (saturating at all-ones) without shifting.
    - Timeout counter clears on every sclkRise.
  - SHIFT, leRise:
    - Next cycle: rxData=shift, rxBitCount=min(bitCnt, WORD_WIDTH), rxValid=1 for exactly one cycle.
    - Set lengthErr if bitCnt != EXPECTED_BITS; this includes overrun frames.
    - Go to IDLE.
  - SHIFT, sclkRise and leRise in the same cycle: the bit is shifted first, then the frame closes with the updated word and count.
  - SHIFT, timeout counter reaches TIMEOUT_CYCLES-1 with no edge: set timeoutErr, discard the frame (no rxValid), go to IDLE.
- Latency: rxValid asserts SYNC_STAGES+2 sysClk cycles after the LE rising edge on the pin.
- rxData and rxBitCount hold their values between strobes.
- Error flags:
  - errClear and a new error event in the same cycle: the set wins.
  - errClear does not affect rxData or the FSM.
- busy = (state == SHIFT).

Test Plan:
- Nominal frame: 16-bit frame 0xA5C3, MSB first, SCLK = sysClk/8, then LE pulse → one rxValid; rxData=0x00A5C3; rxBitCount=16; all error flags 0.
- Short frame: 12 bits 0xFFF then LE → rxValid; rxData=0x000FFF; rxBitCount=12; lengthErr=1. Then errClear → lengthErr=0.
- Overrun: 26 SCLK edges carrying 0xFFFFFF followed by 2 zeros, then LE → rxData=0xFFFFFF (first 24 bits); rxBitCount=24; overrunErr=1; lengthErr=1.
- Timeout: 5 bits, then SCLK stalls for 4096 cycles → timeoutErr=1, busy=0, no rxValid. A following clean 16-bit frame is received correctly.
- Reset mid-frame: drive sysReset_n low for 1 cycle after 8 bits, then send LE → no rxValid; all outputs 0. Next full frame 0x1234 → rxData=0x001234.
- Boundary: LE rise coincident with the 16th SCLK rise (after sync) → the 16th bit is included; rxBitCount=16. LE pulse while IDLE → no strobe, no error.
